// File: rtl/microwave_cook_controller.sv
// Microwave cook sequencer: cook time selection, door-interlocked heating,
// cook-time watchdog and completion beeper. Every output is a register on clk_1Hz.
module microwave_cook_controller #(
  parameter int PIZZA_MIN  = 2,
  parameter int POTATO_MIN = 5,
  parameter int BEEP_SECS  = 3
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       door_open,
  input  logic       pizza,
  input  logic       potato,
  input  logic [5:0] sw_minutes,
  input  logic [5:0] sw_seconds,
  input  logic       timer_end,
  output logic       ctr_rst,
  output logic       ctr_start,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic       magnetron_on,
  output logic       lamp_on,
  output logic       beep,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [5:0] PIZZA_LOAD  = 6'(PIZZA_MIN);
  localparam logic [5:0] POTATO_LOAD = 6'(POTATO_MIN);
  localparam logic [7:0] BEEP_LIMIT  = 8'(BEEP_SECS);

  state_t      cur_state, next_state;
  logic [5:0]  sel_minutes, sel_seconds;
  logic [11:0] total, watchdog_limit;
  logic [11:0] watchdog, watchdog_next;
  logic [7:0]  beep_count, beep_count_next;
  logic        fault_next;
  logic        ctr_rst_next, ctr_start_next, magnetron_next, lamp_next, beep_next;
  logic [5:0]  load_minutes_next, load_seconds_next;

  assign state = cur_state;

  always_comb begin
    sel_minutes = (sw_minutes > 6'd59) ? 6'd59 : sw_minutes;
    sel_seconds = (sw_seconds > 6'd59) ? 6'd59 : sw_seconds;
    if (pizza) begin
      sel_minutes = PIZZA_LOAD;
      sel_seconds = 6'd0;
    end else if (potato) begin
      sel_minutes = POTATO_LOAD;
      sel_seconds = 6'd0;
    end
    total          = 12'(load_minutes) * 12'd60 + 12'(load_seconds);
    watchdog_limit = total + 12'd2;
  end

  // Watchdog counts COOK cycles including the current one, so the limit
  // check below fires after total+3 cycles of heating without timer_end.
  always_comb begin
    next_state  = cur_state;
    fault_next  = fault;
    case (cur_state)
      IDLE: begin
        if (start_btn && !door_open && !fault &&
            (sel_minutes != 6'd0 || sel_seconds != 6'd0))
          next_state = ARM;
      end
      ARM: next_state = COOK;
      COOK: begin
        if (timer_end) begin
          next_state = DONE;
        end else if (door_open || stop_btn) begin
          next_state = PAUSE;
        end else if (watchdog > watchdog_limit) begin
          next_state = DONE;
          fault_next = 1'b1;
        end
      end
      PAUSE: begin
        if (stop_btn)
          next_state = IDLE;
        else if (start_btn && !door_open)
          next_state = COOK;
      end
      DONE: begin
        if (stop_btn || door_open || beep_count >= BEEP_LIMIT)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    watchdog_next = watchdog;
    if (next_state == ARM)
      watchdog_next = 12'd0;
    else if (next_state == COOK)
      watchdog_next = watchdog + 12'd1;

    beep_count_next = 8'd0;
    if (next_state == DONE)
      beep_count_next = (cur_state == DONE) ? beep_count + 8'd1 : 8'd1;

    ctr_rst_next      = (next_state == ARM);
    ctr_start_next    = (next_state == COOK);
    magnetron_next    = (next_state == COOK) && !door_open;
    lamp_next         = (next_state == COOK) || ((next_state == PAUSE) && door_open);
    beep_next         = (next_state == DONE);
    load_minutes_next = (cur_state == IDLE) ? sel_minutes : load_minutes;
    load_seconds_next = (cur_state == IDLE) ? sel_seconds : load_seconds;
  end

  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      cur_state    <= IDLE;
      watchdog     <= 12'd0;
      beep_count   <= 8'd0;
      fault        <= 1'b0;
      ctr_rst      <= 1'b0;
      ctr_start    <= 1'b0;
      magnetron_on <= 1'b0;
      lamp_on      <= 1'b0;
      beep         <= 1'b0;
      load_minutes <= 6'd0;
      load_seconds <= 6'd0;
    end else begin
      cur_state    <= next_state;
      watchdog     <= watchdog_next;
      beep_count   <= beep_count_next;
      fault        <= fault_next;
      ctr_rst      <= ctr_rst_next;
      ctr_start    <= ctr_start_next;
      magnetron_on <= magnetron_next;
      lamp_on      <= lamp_next;
      beep         <= beep_next;
      load_minutes <= load_minutes_next;
      load_seconds <= load_seconds_next;
    end
  end

endmodule

// File: doc/microwave_cook_controller.md
MICROWAVE_COOK_CONTROLLER -- requirements
Module: microwave_cook_controller

Interface
REQ-001 SHALL have parameter PIZZA_MIN, default 2, preset cook minutes for pizza.
REQ-002 SHALL have parameter POTATO_MIN, default 5, preset cook minutes for potato.
REQ-003 SHALL have parameter BEEP_SECS, default 3, DONE beep duration in clk_1Hz cycles.
REQ-004 SHALL have port clk_1Hz  input  1  1 Hz system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_btn  input  1  start/resume request, level sampled each edge.
REQ-007 SHALL have port stop_btn  input  1  pause/cancel request, level sampled each edge.
REQ-008 SHALL have port door_open  input  1  door interlock, 1 = open.
REQ-009 SHALL have port pizza  input  1  pizza preset select.
REQ-010 SHALL have port potato  input  1  potato preset select.
REQ-011 SHALL have port sw_minutes  input  6  manual minutes from switches.
REQ-012 SHALL have port sw_seconds  input  6  manual seconds from switches.
REQ-013 SHALL have port timer_end  input  1  down counter reached 00:00.
REQ-014 SHALL have port ctr_rst  output  1  load pulse to down counter.
REQ-015 SHALL have port ctr_start  output  1  count enable to down counter.
REQ-016 SHALL have port load_minutes  output  6  minutes presented to down counter.
REQ-017 SHALL have port load_seconds  output  6  seconds presented to down counter.
REQ-018 SHALL have port magnetron_on  output  1  heating element enable.
REQ-019 SHALL have port lamp_on  output  1  cavity lamp.
REQ-020 SHALL have port beep  output  1  completion buzzer.
REQ-021 SHALL have port fault  output  1  watchdog fault, sticky until rst.
REQ-022 SHALL have port state  output  3  FSM state: IDLE=0, ARM=1, COOK=2, PAUSE=3, DONE=4.

Function
REQ-023 All outputs SHALL be registered; every output changes only on a clk_1Hz rising edge.
REQ-024 Time selection: pizza wins over potato; preset gives minutes = PIZZA_MIN or POTATO_MIN and seconds = 0; otherwise minutes = min(sw_minutes,59), seconds = min(sw_seconds,59).
REQ-025 load_minutes/load_seconds SHALL track the selection every cycle in IDLE and hold frozen in all other states.
REQ-026 IDLE: all control outputs 0; start_btn=1, door_open=0, fault=0 and selection not 00:00 -> ARM; otherwise stay IDLE.
REQ-027 ARM: ctr_rst=1 for exactly one cycle, watchdog counter cleared; unconditionally -> COOK next edge.
REQ-028 COOK: ctr_start=1, magnetron_on=1, lamp_on=1, watchdog increments by 1 per cycle.
REQ-029 COOK exits, priority order: timer_end -> DONE; else door_open or stop_btn -> PAUSE; else watchdog > total+2 -> DONE with fault=1; total = load_minutes*60+load_seconds, 12-bit unsigned.
REQ-030 PAUSE: ctr_start=0, magnetron_on=0, lamp_on=door_open, watchdog held; stop_btn -> IDLE (cancel, stop wins over start); else start_btn with door_open=0 -> COOK; else stay.
REQ-031 DONE: beep=1, magnetron_on=0, ctr_start=0; beep counter runs BEEP_SECS cycles then -> IDLE; stop_btn or door_open -> IDLE immediately; start_btn ignored.
REQ-032 magnetron_on SHALL never be 1 in any cycle where door_open was 1 at the preceding edge.
REQ-033 Unused state encodings 5-7 SHALL transition to IDLE with all control outputs 0.

Reset
REQ-034 rst=1 at an edge SHALL force state IDLE, all outputs 0, load regs 0, watchdog and beep counters 0, fault 0, overriding all other inputs in any state.

Verification
REQ-035 Manual 00:05, start pulse -> ARM 1 cycle with ctr_rst=1, COOK, timer_end after 5 cycles -> DONE, beep=1 for 3 cycles, IDLE.
REQ-036 pizza=1, potato=1, sw=10:30 -> load_minutes=2, load_seconds=0; start -> COOK with magnetron_on=1.
REQ-037 door_open=1 mid-COOK -> PAUSE next edge, magnetron_on=0, lamp_on=1; door closed + start -> COOK, watchdog resumes from held value.
REQ-038 Selection 00:00 or door_open=1 with start -> remains IDLE; sw=63:63 -> load 59:59.
REQ-039 COOK with total=3 and timer_end never asserted -> DONE with fault=1 after 6 COOK cycles; subsequent start ignored until rst.
REQ-040 rst=1 during COOK -> IDLE, all outputs 0 next edge; stop and start together in PAUSE -> IDLE.
